zero_detect_scheduler: RTL and testbench

Round-robin scheduler that shares a single serial Mealy zero detector among N requesters.
- Each request carries a WIDTH-bit word. The winner's word is shifted MSB-first onto the detector's serial input, one bit per clock.
- The block counts the cycles in which the detector output is high and returns that count to the winner with a done pulse.
- It drives the detector's active-low reset so every frame starts from the detector's idle state (S0). It sits between requester logic and the detector instance.

---
 rtl/zero_detect_scheduler.sv | 156 +++++++++++++++
 tb/tb_zero_detect_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/zero_detect_scheduler.sv
// Round-robin arbiter sharing one serial Mealy zero detector among N requesters.
// Shifts the winner's word MSB-first and returns the detection count with done.
module zero_detect_scheduler #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2,
  parameter int CNT_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] data_in,
  input  logic               y_in,
  output logic               x_out,
  output logic               det_reset,
  output logic [N-1:0]       gnt,
  output logic               busy,
  output logic               done,
  output logic [ID_W-1:0]    done_id,
  output logic [CNT_W-1:0]   zero_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   bit_q, bit_d;
  logic               x_q, x_d;
  logic               drst_q, drst_d;
  logic               done_q, done_d;
  logic [ID_W-1:0]    did_q, did_d;
  logic [CNT_W-1:0]   zc_q, zc_d;

  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W:0]      cand;
  logic [WIDTH-1:0]   win_word;

  // Walk downward so the smallest offset from rr_q+1 wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = N; k >= 1; k--) begin
      cand = {1'b0, rr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N)) cand = cand - (ID_W+1)'(N);
      if (req[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    win_word = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == ID_W'(i)) win_word = data_in[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sreg_d  = sreg_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    x_d     = 1'b0;
    drst_d  = 1'b1;
    done_d  = 1'b0;
    did_d   = did_q;
    zc_d    = zc_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          sreg_d         = win_word;
          rr_d           = win_idx;
          cnt_d          = '0;
          drst_d         = 1'b0;
          state_d        = LOAD;
        end
      end
      LOAD: begin
        x_d     = sreg_q[WIDTH-1];
        sreg_d  = sreg_q << 1;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q + CNT_W'(y_in);
        if (bit_q == CNT_W'(WIDTH-1)) begin
          done_d  = 1'b1;
          zc_d    = cnt_d;
          did_d   = rr_q;
          state_d = DONE;
        end else begin
          x_d    = sreg_q[WIDTH-1];
          sreg_d = sreg_q << 1;
          bit_d  = bit_q + 1'b1;
        end
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sreg_q  <= '0;
      rr_q    <= ID_W'(N-1);
      cnt_q   <= '0;
      bit_q   <= '0;
      x_q     <= 1'b0;
      drst_q  <= 1'b0;
      done_q  <= 1'b0;
      did_q   <= '0;
      zc_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sreg_q  <= sreg_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      x_q     <= x_d;
      drst_q  <= drst_d;
      done_q  <= done_d;
      did_q   <= did_d;
      zc_q    <= zc_d;
    end
  end

  assign x_out      = x_q;
  assign det_reset  = drst_q;
  assign gnt        = gnt_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign done_id    = did_q;
  assign zero_count = zc_q;

endmodule

// File: tb/tb_zero_detect_scheduler.sv
// Bench for zero_detect_scheduler with a behavioural "10" Mealy detector
// and a scoreboard of expected (id, count) results.
module tb_zero_detect_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic        y_in;
  logic        x_out;
  logic        det_reset;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic [3:0]  zero_count;

  zero_detect_scheduler #(
    .N(4), .WIDTH(8), .ID_W(2), .CNT_W(4)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .data_in(data_in),
    .y_in(y_in), .x_out(x_out), .det_reset(det_reset), .gnt(gnt),
    .busy(busy), .done(done), .done_id(done_id), .zero_count(zero_count)
  );

  always #5 clock = ~clock;

  // Detector: state remembers last bit; fires on a 1 followed by a 0.
  logic det_s;
  always @(posedge clock) begin
    if (!det_reset) det_s <= 1'b0;
    else            det_s <= x_out;
  end
  assign y_in = det_s & ~x_out;

  typedef struct {
    logic [1:0] id;
    logic [3:0] cnt;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] count10(input logic [7:0] w);
    logic [3:0] c;
    c = 0;
    for (int i = 7; i >= 1; i--)
      if (w[i] && !w[i-1]) c++;
    return c;
  endfunction

  // Scoreboard consumer and one-hot grant watch.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_id", 32'(done_id), 32'(e.id));
          chk("zero_count", 32'(zero_count), 32'(e.cnt));
        end
      end
    end
  end

  task automatic push(input int id, input logic [7:0] w);
    exp_t t;
    t.id  = 2'(id);
    t.cnt = count10(w);
    sb.push_back(t);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic wait_gnt(input bit nonzero, input string tag);
    int n;
    n = 0;
    while ((gnt != 0) != nonzero && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (n >= 40) chk({tag, "_timeout"}, 32'(gnt), 32'(nonzero));
  endtask

  // One isolated frame for a single requester, fully traced.
  task automatic run_frame(input int idx, input logic [7:0] w);
    data_in[idx*8 +: 8] = w;
    req = 4'(1 << idx);
    push(idx, w);
    @(negedge clock);
    chk("frame_gnt", 32'(gnt), 32'(1 << idx));
    chk("load_det_reset", 32'(det_reset), 32'd0);
    chk("load_x", 32'(x_out), 32'd0);
    req = '0;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clock);
      chk("x_bit", 32'(x_out), 32'(w[i]));
      chk("shift_det_reset", 32'(det_reset), 32'd1);
    end
    @(negedge clock);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_gnt_held", 32'(gnt), 32'(1 << idx));
    @(negedge clock);
    chk("gnt_cleared", 32'(gnt), 32'd0);
    chk("done_fell", 32'(done), 32'd0);
    chk("count_held", 32'(zero_count), 32'(count10(w)));
  endtask

  int t_prev;
  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    data_in = '0;
    reset   = 1'b0;
    req     = '0;
    repeat (2) @(negedge clock);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_zc", 32'(zero_count), 32'd0);
    chk("rst_x", 32'(x_out), 32'd0);
    chk("rst_det_reset", 32'(det_reset), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_det_reset", 32'(det_reset), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    run_frame(0, 8'b1101_1010);
    chk("first_count", 32'(zero_count), 32'd3);
    run_frame(0, 8'h00);
    run_frame(0, 8'hAA);
    chk("aa_count", 32'(zero_count), 32'd4);
    run_frame(0, 8'hFF);

    // All four requesting: round-robin from reset pointer.
    do_reset();
    data_in = {8'h7E, 8'h81, 8'hAA, 8'hDA};
    for (int f = 0; f < 5; f++) push(order[f], data_in[order[f]*8 +: 8]);
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_gnt(1, "rr_rise");
      chk("rr_gnt", 32'(gnt), 32'(1 << order[f]));
      if (f > 0) chk("rr_period", 32'(cyc - t_prev), 32'd11);
      t_prev = cyc;
      wait_gnt(0, "rr_fall");
    end
    req = '0;
    repeat (3) @(negedge clock);

    // Request change mid-frame, then wrap to index 1.
    data_in = {8'h00, 8'hF0, 8'h5A, 8'h00};
    req = 4'b0100;
    push(2, 8'hF0);
    wait_gnt(1, "w_rise");
    chk("w_gnt2", 32'(gnt), 32'b0100);
    repeat (3) @(negedge clock);
    req = 4'b0110;
    data_in[23:16] = 8'hAA;
    wait_gnt(0, "w_fall");
    push(1, 8'h5A);
    wait_gnt(1, "w_rise2");
    chk("w_gnt1", 32'(gnt), 32'b0010);
    req = '0;
    wait_gnt(0, "w_fall2");
    @(negedge clock);
    chk("w_sb_empty", 32'(sb.size()), 32'd0);

    // Abort during SHIFT bit 4.
    data_in[15:8] = 8'h81;
    req = 4'b0010;
    wait_gnt(1, "a_rise");
    req = '0;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_det_reset", 32'(det_reset), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    reset = 1'b1;
    run_frame(1, 8'hAA);

    // Back-to-back: trailing 1 must not leak into next frame.
    run_frame(0, 8'b1000_0001);
    chk("b2b_a", 32'(zero_count), 32'd1);
    run_frame(0, 8'b0111_1110);
    chk("b2b_b", 32'(zero_count), 32'd1);

    repeat (3) @(negedge clock);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
